// File: rtl/vga_box_gen_pkg.sv
// Shared VGA timing and colour constants, plus the types used by the box generator.
// Also used by the sync generator so both agree on the visible area.
package vga_box_gen_pkg;

    localparam int HD   = 640;
    localparam int H_FP = 16;
    localparam int H_BP = 48;
    localparam int H_RT = 96;
    localparam int VD   = 480;
    localparam int V_FP = 10;
    localparam int V_BP = 33;
    localparam int V_RT = 2;

    localparam logic [2:0] BLACK   = 3'b000;
    localparam logic [2:0] BLUE    = 3'b001;
    localparam logic [2:0] GREEN   = 3'b010;
    localparam logic [2:0] CYAN    = 3'b011;
    localparam logic [2:0] RED     = 3'b100;
    localparam logic [2:0] MAGENTA = 3'b101;
    localparam logic [2:0] YELLOW  = 3'b110;
    localparam logic [2:0] WHITE   = 3'b111;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_e;

    typedef struct packed {
        logic hit;
        logic video_on;
        logic hsync;
        logic vsync;
    } stage1_t;

endpackage

// File: rtl/vga_box_gen_box_axis.sv
// One axis of the bouncing box: position and direction, stepped once per enabled frame.
// Clamps exactly onto the edge when the next step would reach or cross it.
module box_axis
    import vga_box_gen_pkg::*;
#(
    parameter int LIMIT = HD,
    parameter int SIZE  = 16,
    parameter int SPEED = 2,
    parameter int P0    = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    output logic [9:0] pos,
    output dir_e       dir
);

    localparam logic [10:0] POS_MAX = 11'(LIMIT - SIZE);
    localparam logic [10:0] STEP    = 11'(SPEED);

    logic [9:0]  pos_q, pos_d;
    dir_e        dir_q, dir_d;
    logic [10:0] pos_ext, pos_inc;

    assign pos_ext = {1'b0, pos_q};
    assign pos_inc = pos_ext + STEP;

    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        if (step) begin
            if (dir_q == DIR_POS) begin
                if (pos_inc >= POS_MAX) begin
                    pos_d = POS_MAX[9:0];
                    dir_d = DIR_NEG;
                end else begin
                    pos_d = pos_inc[9:0];
                end
            end else begin
                if (pos_ext <= STEP) begin
                    pos_d = '0;
                    dir_d = DIR_POS;
                end else begin
                    pos_d = pos_q - STEP[9:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q <= 10'(P0);
            dir_q <= DIR_POS;
        end else begin
            pos_q <= pos_d;
            dir_q <= dir_d;
        end
    end

    assign pos = pos_q;
    assign dir = dir_q;

endmodule

// File: rtl/vga_box_gen.sv
// Bouncing-box pixel stage behind the VGA sync generator: colour and syncs share
// a two-stage p_tick pipeline; position and colour change only at the start of vblank.
module vga_box_gen
    import vga_box_gen_pkg::*;
#(
    parameter int         HD       = vga_box_gen_pkg::HD,
    parameter int         VD       = vga_box_gen_pkg::VD,
    parameter int         SIZE     = 16,
    parameter int         SPEED    = 2,
    parameter int         X0       = 312,
    parameter int         Y0       = 232,
    parameter logic [2:0] BG_COLOR = BLUE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p_tick,
    input  logic       video_on,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [2:0] color_sel,
    input  logic       pause,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] rgb,
    output logic [9:0] box_x,
    output logic [9:0] box_y
);

    logic    frame_tick, move;
    dir_e    dir_x, dir_y;
    logic    dir_unused;
    logic    hit;
    logic [2:0] color_q, color_d;
    stage1_t s1_q, s1_d;
    logic [2:0] rgb_q, rgb_d;
    logic    hsync_q, hsync_d, vsync_q, vsync_d;

    assign frame_tick = p_tick && (pixel_x == 10'd0) && (pixel_y == 10'(VD));
    assign move       = frame_tick && !pause;

    box_axis #(.LIMIT(HD), .SIZE(SIZE), .SPEED(SPEED), .P0(X0)) u_axis_x (
        .clk   (clk),
        .reset (reset),
        .step  (move),
        .pos   (box_x),
        .dir   (dir_x)
    );

    box_axis #(.LIMIT(VD), .SIZE(SIZE), .SPEED(SPEED), .P0(Y0)) u_axis_y (
        .clk   (clk),
        .reset (reset),
        .step  (move),
        .pos   (box_y),
        .dir   (dir_y)
    );

    // Direction is internal to each axis; nothing downstream needs it.
    assign dir_unused = (dir_x == DIR_NEG) ^ (dir_y == DIR_NEG);

    assign hit = ({1'b0, pixel_x} >= {1'b0, box_x}) &&
                 ({1'b0, pixel_x} <  {1'b0, box_x} + 11'(SIZE)) &&
                 ({1'b0, pixel_y} >= {1'b0, box_y}) &&
                 ({1'b0, pixel_y} <  {1'b0, box_y} + 11'(SIZE));

    always_comb begin
        color_d = color_q;
        s1_d    = s1_q;
        rgb_d   = rgb_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        if (frame_tick) begin
            color_d = color_sel;
        end
        if (p_tick) begin
            s1_d = '{hit: hit, video_on: video_on, hsync: hsync_in, vsync: vsync_in};
            if (!s1_q.video_on)  rgb_d = BLACK;
            else if (s1_q.hit)   rgb_d = color_q;
            else                 rgb_d = BG_COLOR;
            hsync_d = s1_q.hsync;
            vsync_d = s1_q.vsync;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            color_q <= WHITE;
            s1_q    <= '0;
            rgb_q   <= '0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            color_q <= color_d;
            s1_q    <= s1_d;
            rgb_q   <= rgb_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign rgb   = rgb_q;
    assign hsync = hsync_q;
    assign vsync = vsync_q;

endmodule

// File: tb/tb_vga_box_gen.sv
// Self-checking bench for vga_box_gen: directed pixels and frame ticks plus random
// pixels, compared against a frame-level reference of box motion and pixel colour.
module tb_vga_box_gen;
    import vga_box_gen_pkg::*;

    localparam int SIZE  = 16;
    localparam int SPEED = 2;
    localparam int X0    = 312;
    localparam int Y0    = 232;
    localparam int XMAX  = HD - SIZE;
    localparam int YMAX  = VD - SIZE;
    localparam int BG    = 1;

    logic       clk = 1'b0;
    logic       reset, p_tick, video_on, hsync_in, vsync_in, pause;
    logic [9:0] pixel_x, pixel_y, box_x, box_y;
    logic [2:0] color_sel, rgb;
    logic       hsync, vsync;

    always #10 clk = ~clk;

    vga_box_gen dut (
        .clk       (clk),
        .reset     (reset),
        .p_tick    (p_tick),
        .video_on  (video_on),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .color_sel (color_sel),
        .pause     (pause),
        .hsync     (hsync),
        .vsync     (vsync),
        .rgb       (rgb),
        .box_x     (box_x),
        .box_y     (box_y)
    );

    int n_chk = 0;
    int n_err = 0;

    // reference state: box, colour, the pixel in flight, and the expected pins
    int m_x, m_y, m_col, e_rgb, frames;
    bit m_xneg, m_yneg, s_hit, s_von, s_hs, s_vs, e_hs, e_vs;

    task automatic check_val(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ":box_x"}, int'(box_x), m_x);
        check_val({tag, ":box_y"}, int'(box_y), m_y);
        check_val({tag, ":rgb"},   int'(rgb),   e_rgb);
        check_val({tag, ":hsync"}, int'(hsync), int'(e_hs));
        check_val({tag, ":vsync"}, int'(vsync), int'(e_vs));
    endtask

    task automatic model_reset();
        m_x = X0; m_y = Y0; m_xneg = 0; m_yneg = 0; m_col = 7;
        s_hit = 0; s_von = 0; s_hs = 0; s_vs = 0;
        e_rgb = 0; e_hs = 0; e_vs = 0; frames = 0;
    endtask

    task automatic axis_step(inout int p, inout bit neg, input int pmax);
        if (!neg) begin
            if (p + SPEED >= pmax) begin p = pmax; neg = 1; end
            else p = p + SPEED;
        end else begin
            if (p <= SPEED) begin p = 0; neg = 0; end
            else p = p - SPEED;
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1; p_tick = 0;
        @(posedge clk); #1;
        model_reset();
        check_all("reset");
        repeat (n - 1) @(posedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    // One pixel: p_tick high for one cycle, then low for one, then compare.
    task automatic pixel(input int x, input int y, input bit von, input bit hs, input bit vs);
        @(negedge clk);
        pixel_x = 10'(x); pixel_y = 10'(y);
        video_on = von; hsync_in = hs; vsync_in = vs; p_tick = 1;
        @(negedge clk);
        p_tick = 0;
        @(posedge clk); #1;
        e_rgb = !s_von ? 0 : (s_hit ? m_col : BG);
        e_hs  = s_hs;
        e_vs  = s_vs;
        s_hit = (x >= m_x) && (x < m_x + SIZE) && (y >= m_y) && (y < m_y + SIZE);
        s_von = von; s_hs = hs; s_vs = vs;
        if (x == 0 && y == VD) begin
            m_col = int'(color_sel);
            if (!pause) begin
                axis_step(m_x, m_xneg, XMAX);
                axis_step(m_y, m_yneg, YMAX);
            end
            frames++;
        end
        check_all("pix");
    endtask

    task automatic rand_pixel();
        int x, y;
        if ($urandom_range(1, 0) == 1) begin
            x = m_x - 2 + int'($urandom_range(SIZE + 3, 0));
            y = m_y - 2 + int'($urandom_range(SIZE + 3, 0));
            if (x < 0) x = 0;
            if (y < 0) y = 0;
        end else begin
            x = int'($urandom_range(799, 0));
            y = int'($urandom_range(524, 0));
        end
        if (x == 0 && y == VD) x = 1;
        pixel(x, y, $urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1);
    endtask

    task automatic frame();
        repeat (3) rand_pixel();
        color_sel = 3'($urandom);
        pixel(0, VD, 0, 0, 1);
    endtask

    initial begin
        bit left_seen, top_seen;
        int bx, by;
        reset = 1; p_tick = 0; video_on = 0; hsync_in = 0; vsync_in = 0;
        pixel_x = 0; pixel_y = 0; color_sel = 0; pause = 0;
        model_reset();

        do_reset(3);
        check_val("reset_box_x", int'(box_x), 312);
        check_val("reset_box_y", int'(box_y), 232);

        // latency: latch red without moving, then a box pixel and a background pixel
        pause = 1; color_sel = 3'b100;
        pixel(0, VD, 0, 0, 0);
        pause = 0; color_sel = 3'b010;
        pixel(312, 232, 1, 0, 0);
        pixel(100, 100, 1, 1, 0);
        check_val("lat_box_rgb", int'(rgb), 4);
        pixel(5, 5, 1, 0, 0);
        check_val("lat_bg_rgb", int'(rgb), 1);
        check_val("lat_hsync", int'(hsync), 1);
        pixel(6, 5, 1, 0, 0);
        check_val("lat_hsync_end", int'(hsync), 0);

        // motion across the screen until both axes have bounced off the low edge
        do_reset(2);
        left_seen = 0; top_seen = 0;
        for (int f = 1; f <= 480; f++) begin
            frame();
            if (f == 155) check_val("right_155", int'(box_x), 622);
            if (f == 156) check_val("right_156", int'(box_x), 624);
            if (f == 157) check_val("right_157", int'(box_x), 622);
            if (f == 116) check_val("bottom_116", int'(box_y), 464);
            if (f == 117) check_val("bottom_117", int'(box_y), 462);
            if (left_seen && m_x == SPEED && m_xneg == 0 && int'(box_x) == SPEED)
                ;
            if (!left_seen && m_x == 0) begin
                left_seen = 1;
                check_val("left_clamp", int'(box_x), 0);
                frame();
                check_val("left_flip", int'(box_x), SPEED);
            end
            if (!top_seen && m_y == 0) begin
                top_seen = 1;
                check_val("top_clamp", int'(box_y), 0);
                frame();
                check_val("top_flip", int'(box_y), SPEED);
            end
        end
        check_val("left_reached", int'(left_seen), 1);
        check_val("top_reached", int'(top_seen), 1);

        // pause freezes motion for 10 frames
        pause = 1; bx = m_x; by = m_y;
        repeat (10) frame();
        check_val("pause_x", int'(box_x), bx);
        check_val("pause_y", int'(box_y), by);
        pause = 0;

        // colour change mid-frame only lands at the next frame tick
        color_sel = 3'b110;
        pixel(0, VD, 0, 0, 0);
        pixel(m_x, 100, 1, 0, 0);
        color_sel = 3'b101;
        repeat (3) pixel(m_x + 1, m_y + 1, 1, 0, 0);
        check_val("col_old", int'(rgb), 6);
        pixel(0, VD, 0, 0, 0);
        repeat (3) pixel(m_x + 1, m_y + 1, 1, 0, 0);
        check_val("col_new", int'(rgb), 5);

        // blanking inside the box
        repeat (2) pixel(m_x + 2, m_y + 2, 0, 0, 0);
        check_val("blank_rgb", int'(rgb), 0);

        // reset mid-frame with all outputs driven high beforehand
        repeat (3) pixel(m_x + 3, m_y + 3, 1, 1, 1);
        pixel(10, 200, 1, 1, 1);
        do_reset(1);
        check_val("mid_rst_rgb", int'(rgb), 0);
        check_val("mid_rst_box_x", int'(box_x), 312);
        pixel(0, VD, 0, 0, 0);
        check_val("resume_x", int'(box_x), 314);
        check_val("resume_y", int'(box_y), 234);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
